// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    // Nibble and decimal point latched for the digit slot being driven
    typedef struct packed {
        logic [3:0] nib;
        logic       dp;
    } slot_cap_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0..F, entry 0 in the low slice
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n_c
);

    assign seg_n_c = HEX_GLYPH[nib];

endmodule

// File: rtl/digit_scan_driver.sv
// Time-multiplexed seven-segment scanner: strobes one digit at a time with an
// optional all-dark gap before each digit to suppress ghosting.
module digit_scan_driver
    import disp_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned DWELL_CYC = 5000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [4*N_DIGITS-1:0]         digit_data,
    input  logic [N_DIGITS-1:0]           dp_in,
    input  logic [N_DIGITS-1:0]           digit_en,
    output logic [N_DIGITS-1:0]           an_n,
    output logic [6:0]                    seg_n,
    output logic                          dp_n,
    output logic [$clog2(N_DIGITS)-1:0]   cur_digit,
    output logic                          frame_tick
);

    localparam int unsigned SEL_W   = $clog2(N_DIGITS);
    localparam int unsigned CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [SEL_W-1:0] LAST_DIGIT = SEL_W'(N_DIGITS - 1);
    localparam scan_state_e      SLOT_START = (BLANK_CYC > 0) ? BLANK : DRIVE;

    scan_state_e           state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [SEL_W-1:0]      dig_nxt;
    slot_cap_t             cap_q, cap_nxt;
    logic                  cap_load;
    logic [N_DIGITS-1:0]   an_nxt;
    logic [N_DIGITS-1:0]   sel_onehot;
    logic [6:0]            seg_nxt;
    logic [6:0]            glyph_c;
    logic                  dp_nxt;
    logic                  tick_nxt;

    hex7seg u_hex7seg (
        .nib     (cap_q.nib),
        .seg_n_c (glyph_c)
    );

    assign sel_onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << cur_digit;

    // Next-state, counter, digit index and next output values
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dig_nxt   = cur_digit;
        cap_load  = 1'b0;
        cap_nxt   = cap_q;
        an_nxt    = '1;
        seg_nxt   = SEG_BLANK;
        dp_nxt    = 1'b1;
        tick_nxt  = 1'b0;

        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            dig_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SLOT_START;
                    cnt_nxt   = '0;
                    dig_nxt   = '0;
                    cap_load  = (SLOT_START == DRIVE);
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = DRIVE;
                        cnt_nxt   = '0;
                        cap_load  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    an_nxt  = ~(sel_onehot & digit_en);
                    seg_nxt = glyph_c;
                    dp_nxt  = ~cap_q.dp;
                    if (cnt == DWELL_LAST) begin
                        state_nxt = SLOT_START;
                        cnt_nxt   = '0;
                        cap_load  = (SLOT_START == DRIVE);
                        if (cur_digit == LAST_DIGIT) begin
                            dig_nxt  = '0;
                            tick_nxt = 1'b1;
                        end else begin
                            dig_nxt = cur_digit + SEL_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    dig_nxt   = '0;
                end
            endcase
        end

        // Latch the slot's nibble on the edge that enters DRIVE; later input changes are ignored
        if (cap_load) begin
            cap_nxt.nib = digit_data[{dig_nxt, 2'b00} +: 4];
            cap_nxt.dp  = dp_in[dig_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_digit  <= '0;
            cap_q      <= '0;
            an_n       <= '1;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cur_digit  <= dig_nxt;
            cap_q      <= cap_nxt;
            an_n       <= an_nxt;
            seg_n      <= seg_nxt;
            dp_n       <= dp_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule
